pipeline_hazard_ctrl: RTL and testbench

- Stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Drives the write-enable and bubble/flush controls of the PC register and the IF_ID, ID_EX, EX_MEM and MEM_WB stage registers.
- Resolves three hazard classes:
  - load-use hazards,
  - taken branches resolved in MEM,
  - multi-cycle data-memory accesses signalled by a req/ready handshake.
- Also drains the un-reset pipeline registers after reset and keeps saturating stall/flush statistics.

---
 rtl/pipeline_hazard_ctrl_if.sv | 44 ++++
 rtl/pipeline_hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage pipeline datapath and its stall/flush sequencer.
// master: the pipeline side (supplies hazard info, consumes stage-register controls).
// slave:  the hazard controller.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  // Hazard information from the pipeline
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             ex_mem_read;
  logic [4:0]       ex_rt;
  logic             mem_pcsrc;
  logic             mem_req;
  logic             mem_ready;

  // Stage-register controls
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_write;
  logic             id_ex_bubble;
  logic             ex_mem_write;
  logic             ex_mem_bubble;
  logic             mem_wb_bubble;

  // Status and statistics
  logic [1:0]       state;
  logic             mem_error;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, mem_pcsrc, mem_req, mem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
           ex_mem_write, ex_mem_bubble, mem_wb_bubble, state, mem_error, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, mem_pcsrc, mem_req, mem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
           ex_mem_write, ex_mem_bubble, mem_wb_bubble, state, mem_error, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the IF/ID/EX/MEM/WB pipeline: post-reset drain, load-use stall,
// taken-branch flush and data-memory wait with timeout, plus saturating statistics.
module pipeline_hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned TIMEOUT      = 16,
  parameter int unsigned CNT_W        = 16
) (
  input logic                    clk,
  input logic                    rst,
  pipeline_hazard_ctrl_if.slave  bus
);

  localparam int unsigned DrainW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int unsigned WaitW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    StDrain   = 2'b00,
    StRun     = 2'b01,
    StMemWait = 2'b10
  } state_e;

  state_e             state_q;
  logic [DrainW-1:0]  drain_q;
  logic [WaitW-1:0]   wait_q;
  logic               mem_error_q;
  logic [CNT_W-1:0]   stall_q;
  logic [CNT_W-1:0]   flush_q;

  logic mem_stall, load_use, wait_timeout, wait_hold, stall_event;
  logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble;
  logic ex_mem_write, ex_mem_bubble, mem_wb_bubble;

  // Hazard decode from the current pipeline contents
  always_comb begin
    mem_stall    = bus.mem_req & ~bus.mem_ready;
    load_use     = bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
                   ((bus.ex_rt == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));
    wait_timeout = (wait_q == WaitW'(TIMEOUT));
    wait_hold    = ~bus.mem_ready & ~wait_timeout;
  end

  // Stage-register controls; rst forces the drain pattern before the state register catches up
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_write  = 1'b1;
    ex_mem_bubble = 1'b0;
    mem_wb_bubble = 1'b0;
    if (rst || (state_q != StRun && state_q != StMemWait)) begin
      pc_write      = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_bubble = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if ((state_q == StRun && mem_stall) || (state_q == StMemWait && wait_hold)) begin
      // Full freeze: only MEM_WB advances, carrying a bubble
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (state_q == StRun && bus.mem_pcsrc) begin
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_bubble = 1'b1;
    end else if (state_q == StRun && load_use) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_bubble  = 1'b1;
    end
    stall_event = (state_q == StRun || state_q == StMemWait) && !pc_write;
  end

  // Sequencer state, sticky error and saturating statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StDrain;
      drain_q     <= '0;
      wait_q      <= '0;
      mem_error_q <= 1'b0;
      stall_q     <= '0;
      flush_q     <= '0;
    end else begin
      if (stall_event && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      case (state_q)
        StDrain: begin
          if (drain_q == DrainW'(DRAIN_CYCLES - 1)) state_q <= StRun;
          else                                      drain_q <= drain_q + 1'b1;
        end
        StRun: begin
          if (mem_stall) begin
            state_q <= StMemWait;
            wait_q  <= WaitW'(1);
          end else if (bus.mem_pcsrc) begin
            if (flush_q != '1) flush_q <= flush_q + 1'b1;
          end
        end
        StMemWait: begin
          if (bus.mem_ready) begin
            state_q <= StRun;
            wait_q  <= '0;
          end else if (wait_timeout) begin
            mem_error_q <= 1'b1;
            state_q     <= StRun;
            wait_q      <= '0;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        default: state_q <= StDrain;
      endcase
    end
  end

  assign bus.pc_write      = pc_write;
  assign bus.if_id_write   = if_id_write;
  assign bus.if_id_flush   = if_id_flush;
  assign bus.id_ex_write   = id_ex_write;
  assign bus.id_ex_bubble  = id_ex_bubble;
  assign bus.ex_mem_write  = ex_mem_write;
  assign bus.ex_mem_bubble = ex_mem_bubble;
  assign bus.mem_wb_bubble = mem_wb_bubble;
  assign bus.state         = state_q;
  assign bus.mem_error     = mem_error_q;
  assign bus.stall_cnt     = stall_q;
  assign bus.flush_cnt     = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: a 16-bit-counter instance and a 4-bit-counter instance share
// stimulus; a behavioural model checks both every cycle, directed checks pin known values.
module tb_pipeline_hazard_ctrl;
  localparam int unsigned DRAIN = 4;
  localparam int unsigned TMO   = 16;

  // Control vector order: pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
  // ex_mem_write, ex_mem_bubble, mem_wb_bubble
  localparam logic [7:0] C_DRAIN   = 8'b0111_1111;
  localparam logic [7:0] C_RUN     = 8'b1101_0100;
  localparam logic [7:0] C_FREEZE  = 8'b0000_0001;
  localparam logic [7:0] C_BRANCH  = 8'b1111_1110;
  localparam logic [7:0] C_LOADUSE = 8'b0001_1100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_hazard_ctrl_if #(.CNT_W(16)) bus_a ();
  pipeline_hazard_ctrl_if #(.CNT_W(4))  bus_b ();

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .TIMEOUT(TMO), .CNT_W(16)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .TIMEOUT(TMO), .CNT_W(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  assign bus_b.id_rs       = bus_a.id_rs;
  assign bus_b.id_rt       = bus_a.id_rt;
  assign bus_b.id_uses_rt  = bus_a.id_uses_rt;
  assign bus_b.ex_mem_read = bus_a.ex_mem_read;
  assign bus_b.ex_rt       = bus_a.ex_rt;
  assign bus_b.mem_pcsrc   = bus_a.mem_pcsrc;
  assign bus_b.mem_req     = bus_a.mem_req;
  assign bus_b.mem_ready   = bus_a.mem_ready;

  logic [7:0] ctrl_a, ctrl_b;
  assign ctrl_a = {bus_a.pc_write, bus_a.if_id_write, bus_a.if_id_flush, bus_a.id_ex_write,
                   bus_a.id_ex_bubble, bus_a.ex_mem_write, bus_a.ex_mem_bubble,
                   bus_a.mem_wb_bubble};
  assign ctrl_b = {bus_b.pc_write, bus_b.if_id_write, bus_b.if_id_flush, bus_b.id_ex_write,
                   bus_b.id_ex_bubble, bus_b.ex_mem_write, bus_b.ex_mem_bubble,
                   bus_b.mem_wb_bubble};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int n, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (n > lim) ? lim : n;
  endfunction

  // Behavioural model: counts of cycles spent draining / waiting and running event totals
  bit m_valid   = 1'b0;
  bit m_drain   = 1'b1;
  bit m_wait    = 1'b0;
  bit m_err     = 1'b0;
  int m_drained = 0;
  int m_waited  = 0;
  int m_stalls  = 0;
  int m_flushes = 0;

  always @(negedge clk) begin
    logic [7:0] exp;
    logic [1:0] exp_state;
    logic       hazard;
    logic       req_stall;
    hazard = bus_a.ex_mem_read && bus_a.ex_rt != 0 &&
             (bus_a.ex_rt == bus_a.id_rs || (bus_a.id_uses_rt && bus_a.ex_rt == bus_a.id_rt));
    req_stall = bus_a.mem_req && !bus_a.mem_ready;
    if (rst || m_drain)      exp = C_DRAIN;
    else if (m_wait)         exp = (!bus_a.mem_ready && m_waited < TMO) ? C_FREEZE : C_RUN;
    else if (req_stall)      exp = C_FREEZE;
    else if (bus_a.mem_pcsrc) exp = C_BRANCH;
    else if (hazard)         exp = C_LOADUSE;
    else                     exp = C_RUN;
    exp_state = m_drain ? 2'd0 : (m_wait ? 2'd2 : 2'd1);

    if (m_valid) begin
      check("model ctrl_a", 32'(ctrl_a), 32'(exp));
      check("model ctrl_b", 32'(ctrl_b), 32'(exp));
      check("model state", 32'(bus_a.state), 32'(exp_state));
      check("model mem_error", 32'(bus_a.mem_error), 32'(m_err));
      check("model stall_cnt_a", 32'(bus_a.stall_cnt), 32'(sat(m_stalls, 16)));
      check("model stall_cnt_b", 32'(bus_b.stall_cnt), 32'(sat(m_stalls, 4)));
      check("model flush_cnt_a", 32'(bus_a.flush_cnt), 32'(sat(m_flushes, 16)));
      check("model flush_cnt_b", 32'(bus_b.flush_cnt), 32'(sat(m_flushes, 4)));
    end

    // Advance the model across the coming rising edge
    if (rst) begin
      m_valid = 1'b1; m_drain = 1'b1; m_wait = 1'b0; m_err = 1'b0;
      m_drained = 0; m_waited = 0; m_stalls = 0; m_flushes = 0;
    end else if (m_drain) begin
      m_drained++;
      if (m_drained == DRAIN) m_drain = 1'b0;
    end else begin
      if (!exp[7]) m_stalls++;
      if (m_wait) begin
        if (bus_a.mem_ready) begin
          m_wait = 1'b0; m_waited = 0;
        end else if (m_waited == TMO) begin
          m_err = 1'b1; m_wait = 1'b0; m_waited = 0;
        end else begin
          m_waited++;
        end
      end else if (req_stall) begin
        m_wait = 1'b1; m_waited = 1;
      end else if (bus_a.mem_pcsrc) begin
        m_flushes++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                        input logic mr, input logic [4:0] ert, input logic pcs,
                        input logic req, input logic rdy);
    bus_a.id_rs = rs; bus_a.id_rt = rt; bus_a.id_uses_rt = ur; bus_a.ex_mem_read = mr;
    bus_a.ex_rt = ert; bus_a.mem_pcsrc = pcs; bus_a.mem_req = req; bus_a.mem_ready = rdy;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    repeat (DRAIN) tick();
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    tick();

    // 1: drain lasts four cycles, PC starts on the fifth
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("drain state", 32'(bus_a.state), 32'd0);
      check("drain ctrl", 32'(ctrl_a), 32'(C_DRAIN));
      tick();
    end
    #1;
    check("run state", 32'(bus_a.state), 32'd1);
    check("first pc_write", 32'(bus_a.pc_write), 32'd1);
    check("stall after drain", 32'(bus_a.stall_cnt), 32'd0);
    tick();

    // 2: load-use on rs, then $zero destination, then rt path gated by id_uses_rt
    set_in(8, 0, 0, 1, 8, 0, 0, 0);
    #1; check("loaduse rs", 32'(ctrl_a), 32'(C_LOADUSE));
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #1; check("after loaduse", 32'(ctrl_a), 32'(C_RUN));
    check("stall one", 32'(bus_a.stall_cnt), 32'd1);
    tick();
    set_in(0, 0, 0, 1, 0, 0, 0, 0);
    #1; check("zero dest", 32'(ctrl_a), 32'(C_RUN));
    tick();
    set_in(3, 9, 1, 1, 9, 0, 0, 0);
    #1; check("loaduse rt", 32'(ctrl_a), 32'(C_LOADUSE));
    tick();
    set_in(3, 9, 0, 1, 9, 0, 0, 0);
    #1; check("rt unused", 32'(ctrl_a), 32'(C_RUN));
    tick();

    // 3: taken branch overrides load-use
    set_in(8, 0, 0, 1, 8, 1, 0, 0);
    #1; check("branch over loaduse", 32'(ctrl_a), 32'(C_BRANCH));
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #1; check("flush one", 32'(bus_a.flush_cnt), 32'd1);
    check("stall unchanged", 32'(bus_a.stall_cnt), 32'd2);
    tick();

    // 4: memory wait of three cycles
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    #1; check("mw freeze1", 32'(ctrl_a), 32'(C_FREEZE));
    check("mw state1", 32'(bus_a.state), 32'd1);
    tick();
    #1; check("mw freeze2", 32'(ctrl_a), 32'(C_FREEZE));
    check("mw state2", 32'(bus_a.state), 32'd2);
    tick();
    #1; check("mw freeze3", 32'(ctrl_a), 32'(C_FREEZE));
    tick();
    set_in(0, 0, 0, 0, 0, 0, 1, 1);
    #1; check("mw release", 32'(ctrl_a), 32'(C_RUN));
    check("mw release state", 32'(bus_a.state), 32'd2);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #1; check("mw back run", 32'(bus_a.state), 32'd1);
    check("mw stalls", 32'(bus_a.stall_cnt), 32'd3);
    tick();

    // 5: timeout after 16 frozen cycles, then a normal handshake
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 16; i++) begin
      #1; check("to freeze", 32'(ctrl_a), 32'(C_FREEZE));
      tick();
    end
    #1; check("to forced", 32'(ctrl_a), 32'(C_RUN));
    check("to err before", 32'(bus_a.mem_error), 32'd0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #1; check("to err set", 32'(bus_a.mem_error), 32'd1);
    check("to state", 32'(bus_a.state), 32'd1);
    check("to stalls", 32'(bus_a.stall_cnt), 32'd16);
    check("to stalls sat", 32'(bus_b.stall_cnt), 32'd15);
    tick();
    tick();
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    #1; check("post-to freeze", 32'(ctrl_a), 32'(C_FREEZE));
    tick();
    set_in(0, 0, 0, 0, 0, 0, 1, 1);
    #1; check("post-to release", 32'(ctrl_a), 32'(C_RUN));
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #1; check("err sticky", 32'(bus_a.mem_error), 32'd1);
    tick();

    // 6: reset mid-wait, then flush-counter saturation
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1; check("rst ctrl", 32'(ctrl_a), 32'(C_DRAIN));
    tick();
    #1; check("rst state", 32'(bus_a.state), 32'd0);
    check("rst err", 32'(bus_a.mem_error), 32'd0);
    check("rst stall", 32'(bus_a.stall_cnt), 32'd0);
    check("rst flush", 32'(bus_a.flush_cnt), 32'd0);
    tick();
    rst = 1'b0;
    repeat (DRAIN) tick();
    set_in(0, 0, 0, 0, 0, 1, 0, 0);
    repeat (20) tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #1; check("flush 20", 32'(bus_a.flush_cnt), 32'd20);
    check("flush sat", 32'(bus_b.flush_cnt), 32'd15);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
